// File: rtl/hazard_scoreboard_if.sv
// Issue/stall bus between the decode stage and the hazard scoreboard.
// The master (decode stage plus MDU done strobe) drives the issuing
// instruction's attributes. The slave (scoreboard) returns the stall
// decisions, the per-register busy vector and the stall-cycle counter.
//   issue_valid/issue_we/issue_dst/issue_lat : instruction and its result latency
//   src_addr/src_en                          : NSRC packed source addresses and enables
//   issue_mdu/issue_hilo_rd/mdu_done         : multiply/divide unit usage and completion
//   stall_raw/stall_waw/stall_mdu/stall_issue: stall reasons and their OR
//   busy_vec                                 : bit r set while register r is pending
//   perf_stall_cnt                           : counted issue stall cycles (0 when disabled)
interface hazard_scoreboard_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned LATW = 3,
  parameter int unsigned NSRC = 2
);
  logic                 issue_valid;
  logic                 issue_we;
  logic [AW-1:0]        issue_dst;
  logic [LATW-1:0]      issue_lat;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC-1:0]      src_en;
  logic                 issue_mdu;
  logic                 issue_hilo_rd;
  logic                 mdu_done;
  logic                 stall_raw;
  logic                 stall_waw;
  logic                 stall_mdu;
  logic                 stall_issue;
  logic [NREG-1:0]      busy_vec;
  logic [31:0]          perf_stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_en,
           issue_mdu, issue_hilo_rd, mdu_done,
    input  stall_raw, stall_waw, stall_mdu, stall_issue, busy_vec, perf_stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_en,
           issue_mdu, issue_hilo_rd, mdu_done,
    output stall_raw, stall_waw, stall_mdu, stall_issue, busy_vec, perf_stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for issue-stage hazard detection.
// Each architectural register (except r0) owns a LATW-bit counter holding
// the number of cycles a consumer must still wait for its pending result.
// RAW, WAW and MDU-busy stalls are decoded from that registered state and
// the current issue request. ext_stall freezes all state; flush clears it.
// Optional feature: define HAZARD_PERF_EN to build a saturating 32-bit
// stall-cycle counter on perf_stall_cnt; otherwise the port is tied to 0.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   ext_stall : global freeze (cache stalls); all state holds
//   flush     : exception/eret flush; clears scoreboard and MDU busy
//   sb        : issue/stall bus (slave side), see hazard_scoreboard_if
module hazard_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned LATW = 3,
  parameter int unsigned NSRC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ext_stall,
  input  logic                flush,
  hazard_scoreboard_if.slave  sb
);

  // Countdown per register; r0 has no entry and always reads as not busy.
  logic [LATW-1:0] cnt [1:NREG-1];
  logic            mdu_busy;

  logic [LATW-1:0] dst_cnt_c;
  logic [NSRC-1:0] src_pend_c;
  logic [NREG-1:0] busy_c;
  logic            raw_c;
  logic            waw_c;
  logic            mdu_c;
  logic            stall_c;
  logic            accept_c;
  logic            load_c;

  // Look up the destination counter and per-source pending flags.
  // Starting at r=1 keeps r0 reads and writes out of the scoreboard.
  always_comb begin
    dst_cnt_c  = '0;
    src_pend_c = '0;
    for (int r = 1; r < NREG; r++) begin
      if (sb.issue_dst == AW'(r)) begin
        dst_cnt_c = cnt[r];
      end
      for (int i = 0; i < NSRC; i++) begin
        if (sb.src_en[i] && (sb.src_addr[i*AW +: AW] == AW'(r)) && (cnt[r] != '0)) begin
          src_pend_c[i] = 1'b1;
        end
      end
    end
  end

  // Busy vector straight from the counters.
  always_comb begin
    busy_c = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_c[r] = (cnt[r] != '0);
    end
  end

  // Stall decode. WAW stalls only while the older write would land after
  // the new one, so writebacks to one register stay in program order.
  // A same-cycle mdu_done lets the HI/LO consumer or next MDU op through.
  always_comb begin
    raw_c    = sb.issue_valid & (|src_pend_c);
    waw_c    = sb.issue_valid & sb.issue_we & (sb.issue_dst != '0) & (dst_cnt_c > sb.issue_lat);
    mdu_c    = sb.issue_valid & (sb.issue_mdu | sb.issue_hilo_rd) & mdu_busy & ~sb.mdu_done;
    stall_c  = raw_c | waw_c | mdu_c;
    accept_c = sb.issue_valid & ~stall_c & ~ext_stall & ~flush;
    load_c   = accept_c & sb.issue_we & (sb.issue_dst != '0) & (sb.issue_lat != '0);
  end

  // Counter update: flush clears, freeze holds, otherwise count down and
  // load the accepted destination (load wins over the decrement).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 1; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else if (!ext_stall) begin
      for (int r = 1; r < NREG; r++) begin
        if (load_c && (sb.issue_dst == AW'(r))) begin
          cnt[r] <= sb.issue_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LATW'(1);
        end
      end
    end
  end

  // MDU busy flag. The MDU keeps running during a freeze, so its done
  // pulse still clears the flag then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_busy <= 1'b0;
    end else if (flush) begin
      mdu_busy <= 1'b0;
    end else if (ext_stall) begin
      if (sb.mdu_done) begin
        mdu_busy <= 1'b0;
      end
    end else begin
      mdu_busy <= (accept_c & sb.issue_mdu) | (mdu_busy & ~sb.mdu_done);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_cnt;

  // Counts issue stalls that actually cost a cycle; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (sb.issue_valid && stall_c && !ext_stall && !flush && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign sb.perf_stall_cnt = perf_cnt;
`else
  assign sb.perf_stall_cnt = '0;
`endif

  assign sb.stall_raw   = raw_c;
  assign sb.stall_waw   = waw_c;
  assign sb.stall_mdu   = mdu_c;
  assign sb.stall_issue = stall_c;
  assign sb.busy_vec    = busy_c;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle stimulus
// with expected stall/busy outputs, queued at drive time and compared on the
// falling edge, plus hand-written reset and stall-counter sequences.
module tb_hazard_scoreboard;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned LATW = 3;
  localparam int unsigned NSRC = 2;

  typedef struct {
    string           name;
    logic            valid;
    logic            we;
    logic [AW-1:0]   dst;
    logic [LATW-1:0] lat;
    logic [AW-1:0]   s0;
    logic [AW-1:0]   s1;
    logic [1:0]      sen;
    logic            mdu;
    logic            hilo;
    logic            done;
    logic            ext;
    logic            fl;
    logic            e_raw;
    logic            e_waw;
    logic            e_mdu;
    logic [31:0]     e_busy;
  } vec_t;

  logic clk;
  logic rst;
  logic ext_stall;
  logic flush;

  int passed;
  int total;
  int exp_perf;

  vec_t tbl[$];
  vec_t exp_q[$];

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .LATW(LATW), .NSRC(NSRC)) sbif ();

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LATW(LATW), .NSRC(NSRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_stall (ext_stall),
    .flush     (flush),
    .sb        (sbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input bit v, input bit we, input int dst, input int lat,
                              input int s0, input int s1, input int sen, input bit mdu, input bit hilo,
                              input bit done, input bit ext, input bit fl,
                              input bit raw, input bit waw, input bit md, input logic [31:0] busy);
    vec_t x;
    x.name = n;   x.valid = v;  x.we = we;
    x.dst = AW'(dst);  x.lat = LATW'(lat);
    x.s0 = AW'(s0);    x.s1 = AW'(s1);  x.sen = 2'(sen);
    x.mdu = mdu;  x.hilo = hilo; x.done = done; x.ext = ext; x.fl = fl;
    x.e_raw = raw; x.e_waw = waw; x.e_mdu = md; x.e_busy = busy;
    return x;
  endfunction

  task automatic idle();
    sbif.issue_valid   = 1'b0;
    sbif.issue_we      = 1'b0;
    sbif.issue_dst     = '0;
    sbif.issue_lat     = '0;
    sbif.src_addr      = '0;
    sbif.src_en        = '0;
    sbif.issue_mdu     = 1'b0;
    sbif.issue_hilo_rd = 1'b0;
    sbif.mdu_done      = 1'b0;
    ext_stall          = 1'b0;
    flush              = 1'b0;
  endtask

  task automatic drive(input vec_t x);
    sbif.issue_valid   = x.valid;
    sbif.issue_we      = x.we;
    sbif.issue_dst     = x.dst;
    sbif.issue_lat     = x.lat;
    sbif.src_addr      = {x.s1, x.s0};
    sbif.src_en        = x.sen;
    sbif.issue_mdu     = x.mdu;
    sbif.issue_hilo_rd = x.hilo;
    sbif.mdu_done      = x.done;
    ext_stall          = x.ext;
    flush              = x.fl;
  endtask

  // Output monitor: one queued expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    vec_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, "stall_raw",   32'(sbif.stall_raw),   32'(e.e_raw));
      chk(e.name, "stall_waw",   32'(sbif.stall_waw),   32'(e.e_waw));
      chk(e.name, "stall_mdu",   32'(sbif.stall_mdu),   32'(e.e_mdu));
      chk(e.name, "stall_issue", 32'(sbif.stall_issue), 32'(e.e_raw | e.e_waw | e.e_mdu));
      chk(e.name, "busy_vec",    sbif.busy_vec,         e.e_busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    passed   = 0;
    total    = 0;
    exp_perf = 0;

    // Load-use: lat=1 gives one stall cycle.
    tbl.push_back(mk("lu0", 1,1,5,1, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("lu1", 1,0,0,0, 5,0,1, 0,0,0,0,0, 1,0,0, 32'h20));
    tbl.push_back(mk("lu2", 1,0,0,0, 5,0,1, 0,0,0,0,0, 0,0,0, 32'h0));
    // Freeze: lat=3 plus 2 frozen cycles -> 5 stall cycles on source 1.
    tbl.push_back(mk("fz0", 1,1,7,3, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("fz1", 1,0,0,0, 0,7,2, 0,0,0,1,0, 1,0,0, 32'h80));
    tbl.push_back(mk("fz2", 1,0,0,0, 0,7,2, 0,0,0,1,0, 1,0,0, 32'h80));
    tbl.push_back(mk("fz3", 1,0,0,0, 0,7,2, 0,0,0,0,0, 1,0,0, 32'h80));
    tbl.push_back(mk("fz4", 1,0,0,0, 0,7,2, 0,0,0,0,0, 1,0,0, 32'h80));
    tbl.push_back(mk("fz5", 1,0,0,0, 0,7,2, 0,0,0,0,0, 1,0,0, 32'h80));
    tbl.push_back(mk("fz6", 1,0,0,0, 0,7,2, 0,0,0,0,0, 0,0,0, 32'h0));
    // r0 never recorded or stalled; WAW stalls while cnt > new latency.
    tbl.push_back(mk("r0w", 1,1,0,3, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("ww1", 1,1,9,3, 0,0,1, 0,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("ww2", 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h200));
    tbl.push_back(mk("ww3", 1,1,9,1, 0,0,0, 0,0,0,0,0, 0,1,0, 32'h200));
    tbl.push_back(mk("ww4", 1,1,9,1, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h200));
    tbl.push_back(mk("ww5", 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h200));
    tbl.push_back(mk("ww6", 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h0));
    // MDU: busy from cycle 0 to the done pulse at cycle 10 (bypassed).
    tbl.push_back(mk("md0", 1,0,0,0, 0,0,0, 1,0,0,0,0, 0,0,0, 32'h0));
    for (int k = 1; k <= 9; k++) begin
      tbl.push_back(mk($sformatf("md%0d", k), 1,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,1, 32'h0));
    end
    tbl.push_back(mk("md10", 1,0,0,0, 0,0,0, 1,1,1,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("md11", 1,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,1, 32'h0));
    tbl.push_back(mk("md12", 0,0,0,0, 0,0,0, 0,0,1,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("md13", 1,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,0, 32'h0));
    // MDU done during a freeze still clears busy.
    tbl.push_back(mk("md14", 1,0,0,0, 0,0,0, 1,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("md15", 1,0,0,0, 0,0,0, 0,1,1,1,0, 0,0,0, 32'h0));
    tbl.push_back(mk("md16", 1,0,0,0, 0,0,0, 0,1,0,0,0, 0,0,0, 32'h0));
    // Flush: clears r3/r4 and MDU busy, ignores the dst=6 write.
    tbl.push_back(mk("fl0", 1,1,3,3, 0,0,0, 1,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("fl1", 1,1,4,1, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h8));
    tbl.push_back(mk("fl2", 1,1,6,2, 0,0,0, 0,0,0,0,1, 0,0,0, 32'h18));
    tbl.push_back(mk("fl3", 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 32'h0));
    tbl.push_back(mk("fl4", 1,0,0,0, 6,3,3, 0,1,0,0,0, 0,0,0, 32'h0));

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset", "busy_vec",    sbif.busy_vec, 32'h0);
    chk("reset", "stall_issue", 32'(sbif.stall_issue), 32'h0);
    chk("reset", "perf",        sbif.perf_stall_cnt, 32'h0);

    // Asynchronous reset with r5 pending and the MDU busy.
    @(posedge clk); #1;
    drive(mk("ar0", 1,1,5,3, 0,0,0, 1,0,0,0,0, 0,0,0, 32'h0));
    @(posedge clk); #1;
    drive(mk("ar1", 1,0,0,0, 5,0,1, 0,1,0,0,0, 0,0,0, 32'h0));
    #2;
    chk("arst_pre", "stall_raw", 32'(sbif.stall_raw), 32'h1);
    chk("arst_pre", "stall_mdu", 32'(sbif.stall_mdu), 32'h1);
    chk("arst_pre", "busy_vec",  sbif.busy_vec, 32'h20);
    rst = 1'b1;
    #1;
    chk("arst", "busy_vec",    sbif.busy_vec, 32'h0);
    chk("arst", "stall_raw",   32'(sbif.stall_raw), 32'h0);
    chk("arst", "stall_waw",   32'(sbif.stall_waw), 32'h0);
    chk("arst", "stall_mdu",   32'(sbif.stall_mdu), 32'h0);
    chk("arst", "stall_issue", 32'(sbif.stall_issue), 32'h0);
    chk("arst", "perf",        sbif.perf_stall_cnt, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table run: drive, queue the expectation, advance one cycle.
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      if (tbl[i].valid && (tbl[i].e_raw || tbl[i].e_waw || tbl[i].e_mdu) && !tbl[i].ext && !tbl[i].fl) begin
        exp_perf++;
      end
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;

`ifdef HAZARD_PERF_EN
    chk("perf", "perf_stall_cnt", sbif.perf_stall_cnt, 32'(exp_perf));
`else
    chk("perf", "perf_stall_cnt", sbif.perf_stall_cnt, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard detector.
- Replaces fixed-stage comparator stall logic with a per-register countdown scoreboard. Arbitrary result latencies (load, CP0, long ops) are tracked, and issue-stage RAW/WAW stalls plus MDU-busy stalls are raised from registered state.
- Sits beside the decode stage. Its stall output feeds the stall/flush aggregation for F/D. The external cache/freeze stall freezes it.

Parameters:
- NREG, 32, number of architectural registers tracked; entry 0 is hard-wired not-busy.
- AW, 5, register address width; must satisfy 2^AW >= NREG.
- LATW, 3, width of each countdown counter; max latency 2^LATW-1.
- NSRC, 2, number of source operands checked per issuing instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ext_stall  in  1  global freeze (i_stall|d_stall); when 1, all state holds.
- flush  in  1  exception/eret flush; clears scoreboard and MDU busy.
- issue_valid  in  1  decode-stage instruction valid.
- issue_we  in  1  instruction writes a GPR.
- issue_dst  in  AW  destination register.
- issue_lat  in  LATW  cycles a consumer must wait; 0 = fully forwardable, no entry.
- src_addr  in  NSRC*AW  source register addresses, source i at bits [i*AW +: AW].
- src_en  in  NSRC  source i is actually read.
- issue_mdu  in  1  instruction starts the multiply/divide unit.
- issue_hilo_rd  in  1  instruction reads HI/LO (mfhi/mflo).
- mdu_done  in  1  MDU result valid this cycle (1-cycle pulse).
- stall_raw  out  1  a source is pending.
- stall_waw  out  1  destination pending with later completion.
- stall_mdu  out  1  MDU busy conflict.
- stall_issue  out  1  stall_raw|stall_waw|stall_mdu.
- busy_vec  out  NREG  bit r = (cnt[r]!=0).
- perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- State: cnt[1..NREG-1], LATW bits each; mdu_busy, 1 bit.
- Reset: all cnt=0, mdu_busy=0. All outputs are 0 after reset.
- Stall outputs are combinational from registered state and current inputs. All are 0 when issue_valid=0.
- stall_raw: any i with src_en[i] & src_addr_i!=0 & cnt[src_addr_i]!=0.
- stall_waw: issue_we & issue_dst!=0 & cnt[issue_dst] > issue_lat (guarantees in-order writeback).
- stall_mdu: (issue_mdu|issue_hilo_rd) & mdu_busy & ~mdu_done. A done pulse bypasses in the same cycle.
- accept = issue_valid & ~stall_issue & ~ext_stall & ~flush.
- Per-cycle update, priority high to low:
  - rst.
  - flush: all cnt<=0, mdu_busy<=0; accept is ignored.
  - ext_stall: everything holds. This includes mdu_busy, except that mdu_done clears it even while frozen (the MDU runs independently).
  - Normal cycle: every nonzero cnt decrements by 1. If accept & issue_we & issue_dst!=0 & issue_lat!=0, cnt[issue_dst]<=issue_lat (load overrides decrement). mdu_busy <= (accept & issue_mdu) | (mdu_busy & ~mdu_done).
- Timing: lat=L gives exactly L stall cycles to an immediately following dependent instruction when unfrozen; frozen cycles add 1:1.
- Writes to r0 are never recorded. Reads of r0 never stall.
- Counters never wrap: decrement only when nonzero.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: 32-bit perf_stall_cnt increments on every cycle with issue_valid & stall_issue & ~ext_stall & ~flush. It saturates at 0xFFFFFFFF, resets to 0, and is not cleared by flush.
- Not defined: perf_stall_cnt is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset: assert rst mid-run with cnt[5]=3 and mdu_busy=1 -> busy_vec=0, all stall outputs 0, mdu_busy cleared immediately (asynchronous).
- Load-use: cycle0 accept dst=5 lat=1; cycle1 src_addr0=5 -> stall_raw=1 for exactly 1 cycle; cycle2 stall_issue=0, busy_vec[5]=0.
- Freeze: dst=7 lat=3 accepted, consumer of r7 follows, ext_stall=1 for 2 cycles in between -> stall_raw high for 5 cycles total; cnt[7] holds during the freeze.
- r0/WAW: dst=0 lat=3 -> busy_vec=0, no stall. dst=9 lat=3 then dst=9 lat=1 next cycle -> stall_waw=1 for 1 cycle (cnt 2>1), accepted when cnt=1.
- MDU: issue_mdu at cycle0, mdu_done at cycle10, issue_hilo_rd held from cycle1 -> stall_mdu=1 for cycles 1-9, 0 at cycle10 (bypass); a new issue_mdu accepted at cycle10 leaves mdu_busy=1.
- Flush: cnt[3]=2, cnt[4]=1, flush together with an accepted dst=6 lat=2 -> next cycle busy_vec=0 and r6 not recorded. With HAZARD_PERF_EN, perf_stall_cnt equals the stall cycles counted in the prior scenarios.
